// File: rtl/uart_tx_arb_if.sv
// Requester-side and UART-TX-side write signals of the shared transmit port.
// slave: arbiter view; master: requester/FIFO (environment) view.
interface uart_tx_arb_if #(
    parameter int unsigned NUM_REQ = 2
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx_data_reg_wr;
    logic [7:0]           tx_data;
    logic                 tx_ready;

    modport slave (
        input  req_valid, req_data, req_last, tx_ready,
        output req_ready, tx_data_reg_wr, tx_data
    );

    modport master (
        output req_valid, req_data, req_last, tx_ready,
        input  req_ready, tx_data_reg_wr, tx_data
    );
endinterface

// File: rtl/uart_tx_arb.sv
// Round-robin, packet-locking arbiter for the UART TX byte write port.
// Optional lock-stall timeout: define UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arb #(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned ID_WIDTH       = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    uart_tx_arb_if.slave        bus,
    output logic [ID_WIDTH-1:0] grant_id,
    output logic                busy,
    output logic                timeout_flag
);

    if (NUM_REQ < 2 || NUM_REQ > 4 || NUM_REQ > (2 ** ID_WIDTH) || TIMEOUT_CYCLES < 2) begin : g_bad_params
        $error("uart_tx_arb: illegal parameter combination");
    end

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t              state, state_nxt;
    logic [ID_WIDTH-1:0] last_grant, last_grant_nxt, grant_nxt;
    logic                own_valid, own_last, accept;
    logic [7:0]          own_data;
    logic                arb_found;
    logic [ID_WIDTH-1:0] arb_winner;

    always_comb begin
        own_valid = 1'b0;
        own_last  = 1'b0;
        own_data  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_id == ID_WIDTH'(i)) begin
                own_valid = bus.req_valid[i];
                own_last  = bus.req_last[i];
                own_data  = bus.req_data[8*i +: 8];
            end
        end
    end

    // First valid requester scanning upward from last_grant+1, wrapping.
    always_comb begin
        arb_found  = 1'b0;
        arb_winner = '0;
        for (int unsigned ofs = 1; ofs <= NUM_REQ; ofs++) begin
            for (int unsigned j = 0; j < NUM_REQ; j++) begin
                if (!arb_found && bus.req_valid[j] &&
                    ((32'(last_grant) + ofs) % NUM_REQ) == j) begin
                    arb_found  = 1'b1;
                    arb_winner = ID_WIDTH'(j);
                end
            end
        end
    end

    // Gated by ARESETn so no byte is reported accepted while reset is applied.
    assign accept = ARESETn && (state == LOCKED) && own_valid && bus.tx_ready;

    always_comb begin
        bus.req_ready = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            bus.req_ready[i] = accept && (grant_id == ID_WIDTH'(i));
        end
        bus.tx_data_reg_wr = accept;
        bus.tx_data        = accept ? own_data : 8'h00;
    end

    assign busy = (state == LOCKED);

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] stall_cnt, stall_cnt_nxt;
    logic             flag_nxt;
`endif

    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant_id;
        last_grant_nxt = last_grant;
`ifdef UART_TX_ARB_TIMEOUT_EN
        stall_cnt_nxt  = '0;
        flag_nxt       = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (arb_found) begin
                    state_nxt      = LOCKED;
                    grant_nxt      = arb_winner;
                    last_grant_nxt = arb_winner;
                end
            end
            LOCKED: begin
                if (accept && own_last) begin
                    state_nxt = IDLE;
                end
`ifdef UART_TX_ARB_TIMEOUT_EN
                // Only an absent owner counts; a FIFO-full stall does not.
                if (!own_valid) begin
                    if (stall_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state_nxt = IDLE;
                        flag_nxt  = 1'b1;
                    end else begin
                        stall_cnt_nxt = stall_cnt + CNT_W'(1);
                    end
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state      <= IDLE;
            grant_id   <= '0;
            last_grant <= ID_WIDTH'(NUM_REQ - 1);
        end else begin
            state      <= state_nxt;
            grant_id   <= grant_nxt;
            last_grant <= last_grant_nxt;
        end
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            stall_cnt    <= '0;
            timeout_flag <= 1'b0;
        end else begin
            stall_cnt    <= stall_cnt_nxt;
            timeout_flag <= flag_nxt;
        end
    end
`else
    assign timeout_flag = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed, table-driven bench for uart_tx_arb (two requesters, 8-cycle timeout).
module tb_uart_tx_arb;

    localparam int unsigned NUM_REQ  = 2;
    localparam int unsigned ID_WIDTH = 2;
    localparam int unsigned TIMEOUT  = 8;

    logic                ACLK = 1'b0;
    logic                ARESETn = 1'b0;
    logic [ID_WIDTH-1:0] grant_id;
    logic                busy;
    logic                timeout_flag;

    uart_tx_arb_if #(.NUM_REQ(NUM_REQ)) bus ();

    uart_tx_arb #(
        .NUM_REQ(NUM_REQ),
        .ID_WIDTH(ID_WIDTH),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .ACLK(ACLK),
        .ARESETn(ARESETn),
        .bus(bus.slave),
        .grant_id(grant_id),
        .busy(busy),
        .timeout_flag(timeout_flag)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic       rst_n;
        logic [1:0] v;
        logic [1:0] l;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       rdy;
        logic [1:0] rr;
        logic       wr;
        logic [7:0] d;
        logic [1:0] g;
        logic       b;
        logic       tf;
    } vec_t;

    int errors = 0;
    int checks = 0;

    function automatic vec_t mk(input logic rst_n, input logic [1:0] v, input logic [1:0] l,
                                input logic [7:0] d0, input logic [7:0] d1, input logic rdy,
                                input logic [1:0] rr, input logic wr, input logic [7:0] d,
                                input logic [1:0] g, input logic b, input logic tf);
        vec_t x;
        x.rst_n = rst_n; x.v = v; x.l = l; x.d0 = d0; x.d1 = d1; x.rdy = rdy;
        x.rr = rr; x.wr = wr; x.d = d; x.g = g; x.b = b; x.tf = tf;
        return x;
    endfunction

    // Drive one cycle of inputs, compare at the falling edge, step past the rising edge.
    task automatic apply(input vec_t x, input string name);
        logic [14:0] act, exp;
        ARESETn       = x.rst_n;
        bus.req_valid = x.v;
        bus.req_last  = x.l;
        bus.req_data  = {x.d1, x.d0};
        bus.tx_ready  = x.rdy;
        @(negedge ACLK);
        act = {bus.req_ready, bus.tx_data_reg_wr, bus.tx_data, grant_id, busy, timeout_flag};
        exp = {x.rr, x.wr, x.d, x.g, x.b, x.tf};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got rr=%b wr=%b d=%h g=%0d busy=%b tf=%b, expected rr=%b wr=%b d=%h g=%0d busy=%b tf=%b",
                     name, bus.req_ready, bus.tx_data_reg_wr, bus.tx_data, grant_id, busy, timeout_flag,
                     x.rr, x.wr, x.d, x.g, x.b, x.tf);
        end
        @(posedge ACLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t tbl[$];

        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_data  = '0;
        bus.tx_ready  = 1'b0;
        ARESETn       = 1'b0;
        repeat (2) @(posedge ACLK);
        #1;

        //            rst  v      l      d0     d1     rdy  rr     wr  d      g  b  tf
        tbl.push_back(mk(0, 2'b00, 2'b00, 8'h00, 8'h00, 1, 2'b00, 0, 8'h00, 0, 0, 0)); // reset state
        tbl.push_back(mk(1, 2'b01, 2'b00, 8'hA1, 8'h00, 1, 2'b00, 0, 8'h00, 0, 0, 0)); // arbitration
        tbl.push_back(mk(1, 2'b01, 2'b00, 8'hA1, 8'h00, 1, 2'b01, 1, 8'hA1, 0, 1, 0));
        tbl.push_back(mk(1, 2'b01, 2'b00, 8'hA2, 8'h00, 1, 2'b01, 1, 8'hA2, 0, 1, 0));
        tbl.push_back(mk(1, 2'b01, 2'b01, 8'hA3, 8'h00, 1, 2'b01, 1, 8'hA3, 0, 1, 0));
        tbl.push_back(mk(1, 2'b00, 2'b00, 8'h00, 8'h00, 1, 2'b00, 0, 8'h00, 0, 0, 0)); // released
        tbl.push_back(mk(0, 2'b11, 2'b00, 8'hB1, 8'hC1, 1, 2'b00, 0, 8'h00, 0, 0, 0)); // reset
        tbl.push_back(mk(1, 2'b11, 2'b00, 8'hB1, 8'hC1, 1, 2'b00, 0, 8'h00, 0, 0, 0)); // req0 wins
        tbl.push_back(mk(1, 2'b11, 2'b00, 8'hB1, 8'hC1, 1, 2'b01, 1, 8'hB1, 0, 1, 0));
        tbl.push_back(mk(1, 2'b11, 2'b01, 8'hB2, 8'hC1, 1, 2'b01, 1, 8'hB2, 0, 1, 0));
        tbl.push_back(mk(1, 2'b10, 2'b00, 8'h00, 8'hC1, 1, 2'b00, 0, 8'h00, 0, 0, 0)); // gap
        tbl.push_back(mk(1, 2'b10, 2'b00, 8'h00, 8'hC1, 1, 2'b10, 1, 8'hC1, 1, 1, 0));
        tbl.push_back(mk(1, 2'b10, 2'b10, 8'h00, 8'hC2, 1, 2'b10, 1, 8'hC2, 1, 1, 0));
        tbl.push_back(mk(1, 2'b11, 2'b11, 8'hD0, 8'hE0, 1, 2'b00, 0, 8'h00, 1, 0, 0)); // rotate to req0
        tbl.push_back(mk(1, 2'b11, 2'b11, 8'hD0, 8'hE0, 1, 2'b01, 1, 8'hD0, 0, 1, 0)); // 1-byte packet
        tbl.push_back(mk(1, 2'b10, 2'b10, 8'h00, 8'hE0, 1, 2'b00, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(1, 2'b10, 2'b10, 8'h00, 8'hE0, 1, 2'b10, 1, 8'hE0, 1, 1, 0));
        tbl.push_back(mk(1, 2'b10, 2'b10, 8'h00, 8'hE1, 1, 2'b00, 0, 8'h00, 1, 0, 0)); // same-source gap
        tbl.push_back(mk(1, 2'b10, 2'b00, 8'h00, 8'hE1, 1, 2'b10, 1, 8'hE1, 1, 1, 0));
        for (int i = 0; i < 5; i++)                                                     // FIFO full stall
            tbl.push_back(mk(1, 2'b11, 2'b00, 8'hF0, 8'hE2, 0, 2'b00, 0, 8'h00, 1, 1, 0));
        tbl.push_back(mk(1, 2'b11, 2'b10, 8'hF0, 8'hE2, 1, 2'b10, 1, 8'hE2, 1, 1, 0)); // resume
        tbl.push_back(mk(1, 2'b01, 2'b01, 8'hF0, 8'h00, 1, 2'b00, 0, 8'h00, 1, 0, 0));
        tbl.push_back(mk(1, 2'b01, 2'b01, 8'hF0, 8'h00, 1, 2'b01, 1, 8'hF0, 0, 1, 0));
        tbl.push_back(mk(1, 2'b10, 2'b00, 8'h00, 8'h11, 1, 2'b00, 0, 8'h00, 0, 0, 0)); // req1 4-byte pkt
        tbl.push_back(mk(1, 2'b10, 2'b00, 8'h00, 8'h11, 1, 2'b10, 1, 8'h11, 1, 1, 0));
        tbl.push_back(mk(1, 2'b10, 2'b00, 8'h00, 8'h22, 1, 2'b10, 1, 8'h22, 1, 1, 0));
        tbl.push_back(mk(0, 2'b11, 2'b00, 8'h44, 8'h33, 1, 2'b00, 0, 8'h00, 1, 1, 0)); // mid-packet reset
        tbl.push_back(mk(1, 2'b11, 2'b00, 8'h44, 8'h33, 1, 2'b00, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(1, 2'b11, 2'b01, 8'h44, 8'h33, 1, 2'b01, 1, 8'h44, 0, 1, 0)); // req0 wins
        tbl.push_back(mk(1, 2'b00, 2'b00, 8'h00, 8'h00, 1, 2'b00, 0, 8'h00, 0, 0, 0));

        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // Owner abandons its packet without a last byte while req0 waits.
        apply(mk(1, 2'b10, 2'b00, 8'h00, 8'h55, 1, 2'b00, 0, 8'h00, 0, 0, 0), "stall_arb");
        apply(mk(1, 2'b10, 2'b00, 8'h00, 8'h55, 1, 2'b10, 1, 8'h55, 1, 1, 0), "stall_byte");
        for (int i = 0; i < 8; i++)
            apply(mk(1, 2'b01, 2'b01, 8'h66, 8'h00, 1, 2'b00, 0, 8'h00, 1, 1, 0),
                  $sformatf("lock_hold%0d", i));
`ifdef UART_TX_ARB_TIMEOUT_EN
        apply(mk(1, 2'b01, 2'b01, 8'h66, 8'h00, 1, 2'b00, 0, 8'h00, 1, 0, 1), "timeout_pulse");
        apply(mk(1, 2'b01, 2'b01, 8'h66, 8'h00, 1, 2'b01, 1, 8'h66, 0, 1, 0), "timeout_regrant");
`else
        for (int i = 8; i < 100; i++)
            apply(mk(1, 2'b01, 2'b01, 8'h66, 8'h00, 1, 2'b00, 0, 8'h00, 1, 1, 0),
                  $sformatf("lock_hold%0d", i));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
